uart_loader: RTL and testbench

UART_LOADER -- requirements
Module: uart_loader

---
 rtl/uart_loader_pkg.sv | 21 ++
 rtl/uart_loader.sv | 136 +++++++++++++
 tb/tb_uart_loader.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_loader_pkg.sv
// Shared command codes, response bytes and FSM state encoding for the UART memory loader.
// Any agent that speaks the loader protocol imports these so the wire format has one definition.
package uart_loader_pkg;

    localparam logic [7:0] CMD_WRITE   = 8'h01;
    localparam logic [7:0] CMD_READ    = 8'h02;
    localparam logic [7:0] ACK_DEFAULT = 8'h06;
    localparam logic [7:0] NAK_DEFAULT = 8'h15;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        LEN   = 3'd2,
        WGET  = 3'd3,
        WMEM  = 3'd4,
        RMEM  = 3'd5,
        RSEND = 3'd6,
        RESP  = 3'd7
    } state_t;

endpackage

// File: rtl/uart_loader.sv
// UART packet loader: pops cmd/addr/len(/data) from the rx FIFO, performs byte memory accesses, pushes ACK/NAK or read data.
// One FIFO op per two cycles at most; rx/tx FIFO empty/full and slow mem_ack stall the FSM indefinitely with outputs held.
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int         ADDR_WIDTH = 32,
    parameter logic [7:0] ACK_BYTE   = ACK_DEFAULT,
    parameter logic [7:0] NAK_BYTE   = NAK_DEFAULT
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  receivable,
    input  logic [7:0]            recv_data,
    output logic                  recv_flag,
    input  logic                  sendable,
    output logic [7:0]            send_data,
    output logic                  send_flag,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    input  logic                  mem_ack,
    input  logic [7:0]            mem_rdata,
    output logic                  busy
);

    state_t      state;
    state_t      state_nxt;
    logic        pop_hold;
    logic        push_hold;
    logic        is_write;
    logic [1:0]  addr_idx;
    logic [31:0] addr_sr;
    logic [8:0]  cnt;
    logic        pop_state;
    logic        push_state;
    logic        last_byte;
    logic        cmd_ok;

    // The hold flags reset high so no FIFO strobe can leak out while RST is asserted.
    always_comb begin
        pop_state  = (state == IDLE) || (state == ADDR) || (state == LEN) || (state == WGET);
        push_state = (state == RSEND) || (state == RESP);
        last_byte  = (cnt == 9'd1);
        cmd_ok     = (recv_data == CMD_WRITE) || (recv_data == CMD_READ);
    end

    assign recv_flag = pop_state && receivable && !pop_hold;
    assign send_flag = push_state && sendable && !push_hold;
    assign mem_req   = (state == WMEM) || (state == RMEM);
    assign mem_we    = (state == WMEM);
    assign busy      = (state != IDLE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (recv_flag) state_nxt = cmd_ok ? ADDR : RESP;
            ADDR:  if (recv_flag && (addr_idx == 2'd3)) state_nxt = LEN;
            LEN:   if (recv_flag) state_nxt = is_write ? WGET : RMEM;
            WGET:  if (recv_flag) state_nxt = WMEM;
            WMEM:  if (mem_ack) state_nxt = last_byte ? RESP : WGET;
            RMEM:  if (mem_ack) state_nxt = RSEND;
            RSEND: if (send_flag) state_nxt = last_byte ? IDLE : RMEM;
            RESP:  if (send_flag) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pop_hold  <= 1'b1;
            push_hold <= 1'b1;
            is_write  <= 1'b0;
            addr_idx  <= 2'd0;
            addr_sr   <= 32'd0;
            cnt       <= 9'd0;
            send_data <= 8'd0;
            mem_addr  <= '0;
            mem_wdata <= 8'd0;
        end else begin
            pop_hold  <= recv_flag;
            push_hold <= send_flag;
            case (state)
                IDLE: begin
                    if (recv_flag) begin
                        is_write <= (recv_data == CMD_WRITE);
                        addr_idx <= 2'd0;
                        if (!cmd_ok) send_data <= NAK_BYTE;
                    end
                end
                ADDR: begin
                    // LSB-first bytes shift in from the top; the cast drops bytes beyond ADDR_WIDTH.
                    if (recv_flag) begin
                        addr_sr  <= {recv_data, addr_sr[31:8]};
                        addr_idx <= addr_idx + 2'd1;
                    end
                end
                LEN: begin
                    if (recv_flag) begin
                        mem_addr <= ADDR_WIDTH'(addr_sr);
                        cnt      <= (recv_data == 8'd0) ? 9'd256 : {1'b0, recv_data};
                    end
                end
                WGET: begin
                    if (recv_flag) mem_wdata <= recv_data;
                end
                WMEM: begin
                    if (mem_ack) begin
                        mem_addr <= mem_addr + ADDR_WIDTH'(1);
                        cnt      <= cnt - 9'd1;
                        if (last_byte) send_data <= ACK_BYTE;
                    end
                end
                RMEM: begin
                    if (mem_ack) send_data <= mem_rdata;
                end
                RSEND: begin
                    if (send_flag) begin
                        mem_addr <= mem_addr + ADDR_WIDTH'(1);
                        cnt      <= cnt - 9'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: FIFO and memory models around the DUT, immediate-assertion checks.
module tb_uart_loader;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        receivable;
    logic [7:0]  recv_data;
    logic        recv_flag;
    logic        sendable;
    logic [7:0]  send_data;
    logic        send_flag;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = 8'd0;
    logic        busy;

    logic [7:0]  rx_buf [0:1023];
    int          rx_wr = 0;
    int          rx_rd = 0;
    logic        rx_en = 1'b1;
    logic        tx_en = 1'b1;
    logic        ack_en = 1'b1;

    logic [31:0] acc_addr [0:511];
    logic        acc_we [0:511];
    logic [7:0]  acc_wdata [0:511];
    int          acc_n = 0;
    logic [7:0]  tx_log [0:31];
    int          tx_n = 0;
    logic [7:0]  rd_vals [0:15];
    int          rd_idx = 0;
    int          viol = 0;
    int          tests = 0;
    int          fails = 0;

    assign receivable = rx_en && (rx_rd != rx_wr);
    assign recv_data  = rx_buf[rx_rd[9:0]];
    assign sendable   = tx_en;

    uart_loader #(
        .ADDR_WIDTH (32),
        .ACK_BYTE   (8'h06),
        .NAK_BYTE   (8'h15)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .receivable (receivable),
        .recv_data  (recv_data),
        .recv_flag  (recv_flag),
        .sendable   (sendable),
        .send_data  (send_data),
        .send_flag  (send_flag),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    // Sample strobes at negedge, act on them just after the following posedge.
    initial begin : models
        logic        rf, sf, prf, psf, mq, mwe;
        logic [31:0] ma;
        logic [7:0]  mwd;
        int          age;
        prf = 1'b0;
        psf = 1'b0;
        age = 0;
        forever begin
            @(negedge CLK);
            rf  = recv_flag;
            sf  = send_flag;
            mq  = mem_req;
            mwe = mem_we;
            ma  = mem_addr;
            mwd = mem_wdata;
            if (rf && !receivable) viol++;
            if (sf && !sendable) viol++;
            if (rf && prf) viol++;
            if (sf && psf) viol++;
            prf = rf;
            psf = sf;
            if (sf) begin
                if (tx_n < 32) tx_log[tx_n] = send_data;
                tx_n++;
            end
            @(posedge CLK);
            #1;
            if (rf) rx_rd++;
            if (mem_ack) begin
                mem_ack = 1'b0;
                age = 0;
            end else if (mq && ack_en) begin
                age++;
                if (age == 2) begin
                    age = 0;
                    mem_ack = 1'b1;
                    mem_rdata = 8'd0;
                    if (!mwe && rd_idx < 16) begin
                        mem_rdata = rd_vals[rd_idx];
                        rd_idx++;
                    end
                    if (acc_n < 512) begin
                        acc_addr[acc_n]  = ma;
                        acc_we[acc_n]    = mwe;
                        acc_wdata[acc_n] = mwd;
                    end
                    acc_n++;
                end
            end else begin
                age = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #3;
    endtask

    task automatic rx_push(input logic [7:0] b);
        rx_buf[rx_wr[9:0]] = b;
        rx_wr++;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen = 1'b0;
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge CLK);
            if (busy) seen = 1'b1;
            else if (seen) done = 1'b1;
        end
        chk(tag, done, 1);
        cyc(1);
    endtask

    initial begin : stim
        int a0;
        int t0;
        int r0;
        bit got;

        // Reset: queue the write packet so a pop during reset would be visible.
        rx_push(8'h01); rx_push(8'h10); rx_push(8'h00); rx_push(8'h00);
        rx_push(8'h00); rx_push(8'h02); rx_push(8'hAA); rx_push(8'hBB);
        cyc(3);
        chk("rst_busy", busy, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_recv_flag", recv_flag, 0);
        chk("rst_send_flag", send_flag, 0);
        chk("rst_send_data", send_data, 8'h00);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 8'h00);
        chk("rst_no_pop", rx_rd, 0);
        RST = 1'b0;

        // Write of two bytes at 0x10.
        wait_done("wr_done", 300);
        chk("wr_count", acc_n, 2);
        chk("wr0_addr", acc_addr[0], 32'h10);
        chk("wr0_we", acc_we[0], 1);
        chk("wr0_data", acc_wdata[0], 8'hAA);
        chk("wr1_addr", acc_addr[1], 32'h11);
        chk("wr1_data", acc_wdata[1], 8'hBB);
        chk("wr_resp_n", tx_n, 1);
        chk("wr_ack", tx_log[0], 8'h06);
        chk("wr_consumed", rx_rd, rx_wr);

        // Read of three bytes at 0x100.
        rd_vals[0] = 8'h11; rd_vals[1] = 8'h22; rd_vals[2] = 8'h33;
        rd_vals[3] = 8'h77; rd_vals[4] = 8'h88;
        a0 = acc_n; t0 = tx_n;
        rx_push(8'h02); rx_push(8'h00); rx_push(8'h01); rx_push(8'h00);
        rx_push(8'h00); rx_push(8'h03);
        wait_done("rd_done", 300);
        chk("rd_count", acc_n - a0, 3);
        chk("rd0_addr", acc_addr[a0], 32'h100);
        chk("rd0_we", acc_we[a0], 0);
        chk("rd1_addr", acc_addr[a0+1], 32'h101);
        chk("rd2_addr", acc_addr[a0+2], 32'h102);
        chk("rd_tx_n", tx_n - t0, 3);
        chk("rd_tx0", tx_log[t0], 8'h11);
        chk("rd_tx1", tx_log[t0+1], 8'h22);
        chk("rd_tx2", tx_log[t0+2], 8'h33);

        // Unknown command then a valid one-byte write.
        a0 = acc_n; t0 = tx_n;
        rx_push(8'h7F);
        wait_done("nak_done", 50);
        chk("nak_tx_n", tx_n - t0, 1);
        chk("nak_byte", tx_log[t0], 8'h15);
        chk("nak_no_mem", acc_n - a0, 0);
        chk("nak_idle", busy, 0);
        rx_push(8'h01); rx_push(8'h20); rx_push(8'h00); rx_push(8'h00);
        rx_push(8'h00); rx_push(8'h01); rx_push(8'h5A);
        wait_done("post_nak_done", 200);
        chk("post_nak_addr", acc_addr[a0], 32'h20);
        chk("post_nak_data", acc_wdata[a0], 8'h5A);
        chk("post_nak_ack", tx_log[t0+1], 8'h06);

        // Back-pressure: rx held between address bytes, tx held 50 cycles during a read.
        a0 = acc_n; t0 = tx_n; r0 = rx_rd;
        rx_push(8'h02); rx_push(8'h00);
        cyc(6);
        rx_en = 1'b0;
        rx_push(8'h03); rx_push(8'h00); rx_push(8'h00); rx_push(8'h02);
        cyc(20);
        chk("bp_rx_hold", rx_rd - r0, 2);
        chk("bp_busy_addr", busy, 1);
        tx_en = 1'b0;
        rx_en = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge CLK);
            if (acc_n > a0) got = 1'b1;
        end
        chk("bp_first_read", got, 1);
        cyc(50);
        chk("bp_tx_hold", tx_n - t0, 0);
        chk("bp_busy_tx", busy, 1);
        tx_en = 1'b1;
        wait_done("bp_done", 200);
        chk("bp_rd_count", acc_n - a0, 2);
        chk("bp_rd0_addr", acc_addr[a0], 32'h300);
        chk("bp_rd1_addr", acc_addr[a0+1], 32'h301);
        chk("bp_tx_n", tx_n - t0, 2);
        chk("bp_tx0", tx_log[t0], 8'h77);
        chk("bp_tx1", tx_log[t0+1], 8'h88);

        // len = 0 write at the top of the address space.
        a0 = acc_n; t0 = tx_n;
        rx_push(8'h01); rx_push(8'hFF); rx_push(8'hFF); rx_push(8'hFF);
        rx_push(8'hFF); rx_push(8'h00);
        for (int i = 0; i < 256; i++) rx_push(8'(i));
        wait_done("wrap_done", 4000);
        chk("wrap_count", acc_n - a0, 256);
        chk("wrap_addr0", acc_addr[a0], 32'hFFFF_FFFF);
        chk("wrap_addr1", acc_addr[a0+1], 32'h0000_0000);
        chk("wrap_data1", acc_wdata[a0+1], 8'h01);
        chk("wrap_addr_last", acc_addr[a0+255], 32'h0000_00FE);
        chk("wrap_data_last", acc_wdata[a0+255], 8'hFF);
        chk("wrap_ack_n", tx_n - t0, 1);
        chk("wrap_ack", tx_log[t0], 8'h06);

        // Reset while a write is waiting for mem_ack.
        ack_en = 1'b0;
        a0 = acc_n; t0 = tx_n;
        rx_push(8'h01); rx_push(8'h40); rx_push(8'h00); rx_push(8'h00);
        rx_push(8'h00); rx_push(8'h01); rx_push(8'hC3);
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge CLK);
            if (mem_req) got = 1'b1;
        end
        chk("wmem_reached", got, 1);
        chk("wmem_we", mem_we, 1);
        chk("wmem_addr", mem_addr, 32'h40);
        chk("wmem_data", mem_wdata, 8'hC3);
        #2;
        RST = 1'b1;
        #1;
        chk("rst_mid_req", mem_req, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_addr", mem_addr, 32'h0);
        cyc(3);
        RST = 1'b0;
        ack_en = 1'b1;
        cyc(10);
        chk("rst_mid_no_ack", tx_n - t0, 0);
        chk("rst_mid_no_acc", acc_n - a0, 0);
        chk("rst_mid_idle", busy, 0);

        chk("fifo_protocol", viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
